// File: rtl/instruction_fetch_pipe.sv
// Instruction fetch unit: owns the PC, drives a synchronous-read instruction
// memory one cycle ahead of the presented instruction, and hands instructions
// to decode over a valid/ready handshake with stall, redirect and halt support.
module instruction_fetch_pipe #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_BITS   = 10,
    parameter logic [DATA_WIDTH-1:0] RESET_PC    = '0,
    parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR = 32'h0000_0100
) (
    input  logic                  Clk,
    input  logic                  Reset,
    output logic [ADDR_BITS-1:0]  Imem_Addr,
    input  logic [DATA_WIDTH-1:0] Imem_Dout,
    output logic [DATA_WIDTH-1:0] Instr,
    output logic                  Instr_Valid,
    input  logic                  Instr_Ready,
    output logic [DATA_WIDTH-1:0] PC_Out,
    input  logic                  Redirect,
    input  logic [1:0]            Redirect_Mode,
    input  logic [DATA_WIDTH-1:0] Redirect_Base,
    input  logic [DATA_WIDTH-1:0] PC_Immed,
    input  logic                  Halt,
    output logic                  Halted
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    localparam logic [DATA_WIDTH-1:0] WORD_BYTES = DATA_WIDTH'(4);
    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~(DATA_WIDTH'(3));

    fetch_state_t          state;
    fetch_state_t          next_state;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] next_pc;
    logic                  instr_valid;
    logic                  next_valid;
    logic [DATA_WIDTH-1:0] raw_target;
    logic [DATA_WIDTH-1:0] redirect_target;

    // Pick the redirect destination by mode and force it onto a word boundary.
    always_comb begin
        raw_target = PC_Immed;
        case (Redirect_Mode)
            2'b00:   raw_target = Redirect_Base + WORD_BYTES + PC_Immed;
            2'b10:   raw_target = TRAP_VECTOR;
            default: raw_target = PC_Immed;
        endcase
        redirect_target = raw_target & ALIGN_MASK;
    end

    // State, PC and valid registers; PC is always loaded with next_pc so the
    // memory address issued this cycle matches the PC presented next cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= ST_BOOT;
            pc          <= RESET_PC;
            instr_valid <= 1'b0;
        end else begin
            state       <= next_state;
            pc          <= next_pc;
            instr_valid <= next_valid;
        end
    end

    // Next-state logic: reset beats redirect, redirect beats halt, halt beats advance.
    always_comb begin
        next_state = state;
        next_pc    = pc;
        next_valid = instr_valid;
        if (Reset) begin
            next_state = ST_BOOT;
            next_pc    = RESET_PC;
            next_valid = 1'b0;
        end else if (Redirect) begin
            next_state = ST_RUN;
            next_pc    = redirect_target;
            next_valid = 1'b1;
        end else begin
            case (state)
                ST_BOOT: begin
                    next_state = ST_RUN;
                    next_valid = 1'b1;
                end
                ST_RUN: begin
                    if (Halt) begin
                        next_state = ST_HALT;
                        next_valid = 1'b0;
                    end else if (instr_valid && Instr_Ready) begin
                        next_pc = pc + WORD_BYTES;
                    end
                end
                ST_HALT: begin
                    next_valid = 1'b0;
                end
                default: begin
                    next_state = ST_BOOT;
                    next_pc    = RESET_PC;
                    next_valid = 1'b0;
                end
            endcase
        end
    end

    // Outputs: memory is addressed from next_pc, the instruction comes straight from memory.
    always_comb begin
        Imem_Addr   = next_pc[ADDR_BITS+1:2];
        Instr       = Imem_Dout;
        PC_Out      = pc;
        Instr_Valid = instr_valid;
        Halted      = (state == ST_HALT);
    end

endmodule

// File: tb/tb_instruction_fetch_pipe.sv
// Testbench for instruction_fetch_pipe: directed vector table, hand-written
// reset/boot corner sequences, then randomized traffic against a reference model.
module tb_instruction_fetch_pipe;

    localparam int DW = 32;
    localparam int AB = 10;
    localparam logic [DW-1:0] TRAP = 32'h0000_0100;

    logic          Clk = 1'b0;
    logic          Reset;
    logic [AB-1:0] Imem_Addr;
    logic [DW-1:0] Imem_Dout;
    logic [DW-1:0] Instr;
    logic          Instr_Valid;
    logic          Instr_Ready;
    logic [DW-1:0] PC_Out;
    logic          Redirect;
    logic [1:0]    Redirect_Mode;
    logic [DW-1:0] Redirect_Base;
    logic [DW-1:0] PC_Immed;
    logic          Halt;
    logic          Halted;

    logic [DW-1:0] mem [0:(1<<AB)-1];

    int checks   = 0;
    int failures = 0;

    // Reference model: what the fetch stream should look like after each edge.
    logic [DW-1:0] mPc;
    logic          mValid;
    logic          mHalted;
    logic          mBoot;

    typedef struct {
        logic          r;
        logic          d;
        logic [1:0]    m;
        logic [DW-1:0] b;
        logic [DW-1:0] i;
        logic          h;
        logic          y;
        logic          ev;
        logic [DW-1:0] epc;
        logic          eh;
    } vec_t;

    vec_t vecs[$];

    instruction_fetch_pipe #(
        .DATA_WIDTH (DW),
        .ADDR_BITS  (AB),
        .RESET_PC   (32'h0),
        .TRAP_VECTOR(TRAP)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Imem_Addr    (Imem_Addr),
        .Imem_Dout    (Imem_Dout),
        .Instr        (Instr),
        .Instr_Valid  (Instr_Valid),
        .Instr_Ready  (Instr_Ready),
        .PC_Out       (PC_Out),
        .Redirect     (Redirect),
        .Redirect_Mode(Redirect_Mode),
        .Redirect_Base(Redirect_Base),
        .PC_Immed     (PC_Immed),
        .Halt         (Halt),
        .Halted       (Halted)
    );

    // Free-running clock.
    always #5 Clk = ~Clk;

    // Synchronous-read instruction memory with one cycle of latency.
    always @(posedge Clk) Imem_Dout <= mem[Imem_Addr];

    function automatic logic [DW-1:0] memWord(input logic [DW-1:0] pc);
        return 32'hA000_0000 + ((pc >> 2) & 32'd1023);
    endfunction

    function automatic logic [DW-1:0] targetOf(input logic [1:0] mode,
                                               input logic [DW-1:0] base,
                                               input logic [DW-1:0] imm);
        logic [DW-1:0] t;
        if (mode == 2'b00)      t = base + 32'd4 + imm;
        else if (mode == 2'b10) t = TRAP;
        else                    t = imm;
        return {t[DW-1:2], 2'b00};
    endfunction

    // Where the fetch stream goes next given the inputs currently driven.
    task automatic modelNext(output logic [DW-1:0] nPc, output logic nValid,
                             output logic nHalted, output logic nBoot);
        nPc = mPc; nValid = mValid; nHalted = mHalted; nBoot = mBoot;
        if (Reset) begin
            nPc = 32'h0; nValid = 1'b0; nHalted = 1'b0; nBoot = 1'b1;
        end else if (Redirect) begin
            nPc = targetOf(Redirect_Mode, Redirect_Base, PC_Immed);
            nValid = 1'b1; nHalted = 1'b0; nBoot = 1'b0;
        end else if (mBoot) begin
            nValid = 1'b1; nBoot = 1'b0;
        end else if (mHalted) begin
            nValid = 1'b0;
        end else if (Halt) begin
            nValid = 1'b0; nHalted = 1'b1;
        end else if (Instr_Ready) begin
            nPc = mPc + 32'd4;
        end
    endtask

    task automatic checkVal(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, check the memory address, clock, advance the model.
    task automatic applyStimulus(input logic r, input logic d, input logic [1:0] m,
                                 input logic [DW-1:0] b, input logic [DW-1:0] i,
                                 input logic h, input logic y);
        logic [DW-1:0] nPc;
        logic nValid, nHalted, nBoot;
        Reset = r; Redirect = d; Redirect_Mode = m; Redirect_Base = b;
        PC_Immed = i; Halt = h; Instr_Ready = y;
        #1;
        modelNext(nPc, nValid, nHalted, nBoot);
        checkVal("imem_addr", {{(DW-AB){1'b0}}, Imem_Addr}, {{(DW-AB){1'b0}}, nPc[AB+1:2]});
        @(posedge Clk);
        mPc = nPc; mValid = nValid; mHalted = nHalted; mBoot = nBoot;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic ev, input logic [DW-1:0] epc, input logic eh);
        checkVal({name, ".valid"}, {31'b0, Instr_Valid}, {31'b0, ev});
        checkVal({name, ".halted"}, {31'b0, Halted}, {31'b0, eh});
        if (ev) begin
            checkVal({name, ".pc"}, PC_Out, epc);
            checkVal({name, ".instr"}, Instr, memWord(epc));
        end else if (!Reset) begin
            checkVal({name, ".pc"}, PC_Out, epc);
        end
    endtask

    function automatic void addVec(input logic r, input logic d, input logic [1:0] m,
                                   input logic [DW-1:0] b, input logic [DW-1:0] i,
                                   input logic h, input logic y,
                                   input logic ev, input logic [DW-1:0] epc, input logic eh);
        vec_t v;
        v.r = r; v.d = d; v.m = m; v.b = b; v.i = i; v.h = h; v.y = y;
        v.ev = ev; v.epc = epc; v.eh = eh;
        vecs.push_back(v);
    endfunction

    initial begin
        for (int n = 0; n < (1 << AB); n++) mem[n] = 32'hA000_0000 + n;
        mPc = 32'h0; mValid = 1'b0; mHalted = 1'b0; mBoot = 1'b1;

        //     r  d  m      base          immed         h  y   ev  pc            halted
        addVec(1, 0, 2'b00, 32'h0,        32'h0,        0, 1,  0,  32'h0,        0);
        addVec(1, 0, 2'b00, 32'h0,        32'h0,        0, 1,  0,  32'h0,        0);
        addVec(0, 0, 2'b00, 32'h0,        32'h0,        0, 1,  1,  32'h0,        0);
        addVec(0, 0, 2'b00, 32'h0,        32'h0,        0, 1,  1,  32'h4,        0);
        addVec(0, 0, 2'b00, 32'h0,        32'h0,        0, 1,  1,  32'h8,        0);
        addVec(0, 0, 2'b00, 32'h0,        32'h0,        0, 0,  1,  32'h8,        0);
        addVec(0, 0, 2'b00, 32'h0,        32'h0,        0, 0,  1,  32'h8,        0);
        addVec(0, 0, 2'b00, 32'h0,        32'h0,        0, 0,  1,  32'h8,        0);
        addVec(0, 0, 2'b00, 32'h0,        32'h0,        0, 1,  1,  32'hC,        0);
        addVec(0, 0, 2'b00, 32'h0,        32'h0,        0, 1,  1,  32'h10,       0);
        addVec(0, 1, 2'b00, 32'h8,        32'h10,       0, 0,  1,  32'h1C,       0);
        addVec(0, 1, 2'b01, 32'h0,        32'h43,       0, 1,  1,  32'h40,       0);
        addVec(0, 1, 2'b10, 32'h0,        32'h0,        0, 0,  1,  32'h100,      0);
        addVec(0, 0, 2'b00, 32'h0,        32'h0,        0, 1,  1,  32'h104,      0);
        addVec(0, 1, 2'b11, 32'h0,        32'hFFC,      0, 0,  1,  32'hFFC,      0);
        addVec(0, 0, 2'b00, 32'h0,        32'h0,        0, 1,  1,  32'h1000,     0);
        addVec(0, 0, 2'b00, 32'h0,        32'h0,        1, 1,  0,  32'h1000,     1);
        addVec(0, 0, 2'b00, 32'h0,        32'h0,        0, 0,  0,  32'h1000,     1);
        addVec(0, 0, 2'b00, 32'h0,        32'h0,        0, 1,  0,  32'h1000,     1);
        addVec(0, 1, 2'b01, 32'h0,        32'h20,       1, 0,  1,  32'h20,       0);
        addVec(0, 0, 2'b00, 32'h0,        32'h0,        0, 1,  1,  32'h24,       0);
        addVec(0, 1, 2'b00, 32'hFFFF_FFF8, 32'h0,       0, 1,  1,  32'hFFFF_FFFC, 0);
        addVec(0, 0, 2'b00, 32'h0,        32'h0,        0, 1,  1,  32'h0,        0);

        foreach (vecs[k]) begin
            applyStimulus(vecs[k].r, vecs[k].d, vecs[k].m, vecs[k].b, vecs[k].i, vecs[k].h, vecs[k].y);
            checkOutput($sformatf("vec%0d", k), vecs[k].ev, vecs[k].epc, vecs[k].eh);
        end

        // Reset in the middle of a stall, with a redirect that must be ignored.
        applyStimulus(0, 0, 2'b00, 32'h0, 32'h0, 0, 0);
        checkOutput("stall_pre_reset", 1, 32'h0, 0);
        applyStimulus(1, 1, 2'b01, 32'h0, 32'h80, 0, 0);
        checkOutput("reset_beats_redirect", 0, 32'h0, 0);
        applyStimulus(0, 0, 2'b00, 32'h0, 32'h0, 0, 0);
        checkOutput("boot_after_reset", 1, 32'h0, 0);
        applyStimulus(0, 0, 2'b00, 32'h0, 32'h0, 0, 1);
        checkOutput("advance_after_boot", 1, 32'h4, 0);

        // Redirect arriving during the boot cycle takes over the stream.
        applyStimulus(1, 0, 2'b00, 32'h0, 32'h0, 0, 1);
        checkOutput("reset_again", 0, 32'h0, 0);
        applyStimulus(0, 1, 2'b01, 32'h0, 32'h30, 0, 1);
        checkOutput("redirect_in_boot", 1, 32'h30, 0);
        applyStimulus(0, 0, 2'b00, 32'h0, 32'h0, 0, 1);
        checkOutput("advance_after_boot_redirect", 1, 32'h34, 0);

        // Randomized traffic compared cycle by cycle against the model.
        for (int c = 0; c < 400; c++) begin
            logic r, d, h, y;
            logic [1:0] m;
            logic [DW-1:0] b, i;
            r = ($urandom_range(99, 0) < 2);
            d = ($urandom_range(99, 0) < 12);
            h = ($urandom_range(99, 0) < 8);
            y = ($urandom_range(99, 0) < 70);
            m = 2'($urandom_range(3, 0));
            b = $urandom;
            i = ($urandom_range(1, 0) == 1) ? 32'($urandom_range(4095, 0)) : $urandom;
            applyStimulus(r, d, m, b, i, h, y);
            checkOutput($sformatf("rand%0d", c), mValid, mPc, mHalted);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_pipe.md
Name: instruction_fetch_pipe

Overview:
Parametrised fetch unit with a valid/ready output handshake, stall and redirect support, and a halt state. It owns the PC register and drives the address of an external synchronous-read instruction memory (1-cycle read latency). It presents one instruction per cycle to decode. Redirects come from later stages: relative branch, absolute jump, or trap vector.

Parameters:
DATA_WIDTH, 32, width of PC, immediates and instruction word
ADDR_BITS, 10, word-address width of instruction memory (Imem_Addr = PC[ADDR_BITS+1:2])
RESET_PC, 0, PC value after reset
TRAP_VECTOR, 32'h0000_0100, redirect target for trap mode

Ports:
Clk  in  1  clock, all state updates on rising edge
Reset  in  1  synchronous, active-high reset
Imem_Addr  out  ADDR_BITS  word address to instruction memory; combinational from next_pc
Imem_Dout  in  DATA_WIDTH  memory read data, valid one cycle after address sampled
Instr  out  DATA_WIDTH  instruction at PC_Out; equals Imem_Dout
Instr_Valid  out  1  Instr/PC_Out hold a fetched instruction
Instr_Ready  in  1  decode accepts Instr this cycle
PC_Out  out  DATA_WIDTH  address of presented instruction (PC register)
Redirect  in  1  change fetch stream this cycle
Redirect_Mode  in  2  00 relative, 01 absolute, 10 trap, 11 = absolute
Redirect_Base  in  DATA_WIDTH  PC of redirecting instruction (relative mode)
PC_Immed  in  DATA_WIDTH  byte offset (relative) or target (absolute)
Halt  in  1  stop fetching until next Redirect
Halted  out  1  state == HALT

Behaviour:
- next_pc is the address loaded into PC at the edge. Imem_Addr = next_pc[ADDR_BITS+1:2]. The memory therefore returns mem[PC] during the cycle after the edge. Instr is never registered separately.
- Targets:
  - relative = Redirect_Base + 4 + PC_Immed
  - absolute = PC_Immed
  - trap = TRAP_VECTOR
  - Bits [1:0] are forced to 0.
  - All adds are DATA_WIDTH bits and wrap modulo 2^DATA_WIDTH. Imem_Addr wraps within 2^ADDR_BITS words.
- FSM states BOOT, RUN, HALT. Priority: Reset > Redirect > Halt > advance.
- Reset (any state, mid-stream included) → PC=RESET_PC, Instr_Valid=0, state=BOOT, Halted=0. next_pc=RESET_PC while Reset is high.
- BOOT (one cycle):
  - next_pc=PC, so RESET_PC is refetched.
  - Instr_Valid<=1, state<=RUN.
  - A Redirect in BOOT takes priority: next_pc=target, Instr_Valid<=1, RUN.
- RUN:
  - Redirect: next_pc=target, Instr_Valid<=1. The presented instruction is squashed even if Instr_Ready=1. Target instruction is valid in the next cycle (1-cycle redirect latency).
  - Else Halt: next_pc=PC, Instr_Valid<=0, state<=HALT. The presented instruction is dropped whether or not Ready is high.
  - Else Instr_Valid && Instr_Ready: next_pc=PC+4 (handshake completes).
  - Else (stall): next_pc=PC. The memory re-reads the same word, so Instr and PC_Out stay stable.
- HALT:
  - Instr_Valid=0, Halted=1, PC held. Instr_Ready is ignored.
  - Only Redirect leaves HALT: next_pc=target, Instr_Valid<=1, state<=RUN. Halt and Redirect together → Redirect wins.
- Handshake rule: while Instr_Valid=1 and Instr_Ready=0, Instr and PC_Out must not change unless Redirect, Halt or Reset is asserted.
- Throughput is one instruction per cycle with Ready held high.

Test Plan:
1. Reset high 2 cycles, memory word n = 0xA000_0000+n, Ready=1 → first Valid cycle is cycle 2 after reset release, with PC_Out=0, Instr=0xA000_0000. Then PC_Out=4, 8, 12 on consecutive cycles.
2. Stall: Ready=0 for 3 cycles at PC_Out=8 → Instr=0xA000_0002 and PC_Out=8 stable, Valid=1. Ready=1 → next cycle PC_Out=12.
3. Redirect relative, Base=8, PC_Immed=0x10, Ready=0 → next cycle PC_Out=0x1C, Valid=1. The instruction at 8 is never counted as accepted.
4. Redirect absolute PC_Immed=0x0000_0043, then trap mode → PC_Out=0x40, then PC_Out=0x100. With ADDR_BITS=10, PC 0xFFC+4 → Imem_Addr wraps to 0.
5. Halt in RUN → Valid=0 and Halted=1 next cycle. Ready toggling has no effect. Halt+Redirect absolute 0x20 in same cycle → RUN, PC_Out=0x20, Valid=1.
6. Reset asserted mid-stall with Redirect also high → Redirect ignored. PC_Out=RESET_PC, Valid=0, then BOOT → Valid=1 at RESET_PC.
